fetch_ctrl: RTL
===============

# fetch_ctrl

Sequencer for the instruction-fetch stage of the PIPE five-stage pipeline. It owns the PC. It drives a req/ack instruction-memory handshake that tolerates wait states, and it loads the IF/ID pipeline register. It arbitrates three events: branch redirects from EX/MEM, hold requests from the ID hazard unit, and memory completion. In-flight fetches are never aborted; they are drained and discarded.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value after reset
- NOP, 32'h0000_0000, value loaded into IF_ID_IR on bubble or flush

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; clears all state immediately
- EX_MEM_Cond  in  1  branch taken (redirect request), sampled every cycle
- EX_MEM_ALU_output  in  32  redirect target; bits [1:0] ignored
- ID_stall  in  1  ID cannot accept a new instruction this cycle
- imem_req  out  1  fetch request; held high with stable imem_addr until ack
- imem_addr  out  32  word-aligned fetch address
- imem_ack  in  1  imem_rdata valid this cycle; may assert in the same cycle as imem_req
- imem_rdata  in  32  fetched instruction
- IF_ID_IR  out  32  registered instruction
- IF_ID_NPC  out  32  registered PC+4 of IF_ID_IR
- IF_ID_valid  out  1  IF/ID holds a real instruction
- pc  out  32  current fetch PC

## Operation
Reset values: state BOOT, pc = RESET_PC, IF_ID_IR = NOP, IF_ID_NPC = 0, IF_ID_valid = 0, imem_req = 0, target register = 0.

Outputs:
- imem_req = 1 in FETCH and DRAIN; 0 otherwise.
- imem_addr = {pc[31:2], 2'b00}.
- pc arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 wraps to 0.

States:
- BOOT: one idle cycle, then FETCH.
- FETCH (request outstanding):
  - ack, no redirect, !ID_stall: IF_ID <= {rdata, pc+4, valid=1}; pc <= pc+4; stay in FETCH. Back-to-back fetches are allowed.
  - ack, no redirect, ID_stall: hold_ir <= rdata; go to HOLD. IF/ID is unchanged.
  - no ack, no redirect: if !ID_stall, IF/ID <= bubble (IR = NOP, valid = 0); otherwise IF/ID is unchanged.
  - redirect with ack: discard rdata; pc <= target; IF/ID <= bubble; stay in FETCH.
  - redirect without ack: target_q <= target; IF/ID <= bubble; go to DRAIN.
- HOLD (data buffered, imem_req = 0):
  - !ID_stall: IF_ID <= {hold_ir, pc+4, 1}; pc <= pc+4; go to FETCH.
  - redirect: discard hold_ir; pc <= target; IF/ID <= bubble; go to FETCH.
- DRAIN (discarding the stale fetch):
  - imem_addr stays at the old pc until ack.
  - On ack: discard rdata; pc <= target_q; go to FETCH.
  - A new redirect while in DRAIN overwrites target_q. If it arrives in the same cycle as ack, the new target wins.
  - IF/ID is held as a bubble throughout.

Priority: redirect > ID_stall > normal advance. A redirect always bubbles IF/ID on the next edge, even while ID_stall is high.

## Timing
- Zero-wait memory (ack in the same cycle as req): one instruction per cycle. Request at edge N, IF_ID_valid at edge N+1.
- k wait states: IF_ID_valid rises one cycle after ack.
- Redirect to first target fetch:
  - Redirect in the ack cycle: 0 extra cycles; target request on the next cycle.
  - Otherwise: remaining drain cycles, plus 1.
- Stall release from HOLD: the instruction appears in IF/ID on the next edge, with no memory re-fetch.
- Reset asserted mid-DRAIN or mid-HOLD: all state clears asynchronously. imem_req drops immediately; no ack is expected afterwards.

## Structure
- Shared package pipe_pkg:
  - state enum (BOOT, FETCH, HOLD, DRAIN)
  - NOP constant
  - default RESET_PC
- Sub-module if_id_reg: IR/NPC/valid register with load and flush inputs (flush has priority), reset to NOP/0/0.
- FSM, PC, hold_ir and target_q stay in fetch_ctrl.

## Test plan
- Reset release, zero-wait memory returning addr+32'h100 as data: imem_addr runs 0, 4, 8; IF_ID_IR = 100, 104, 108 on consecutive edges; IF_ID_NPC = 4, 8, C.
- Ack delayed 3 cycles on addr 4: imem_req high with addr 4 for 4 cycles; IF_ID_valid = 0 for 3 cycles, then IR = 104.
- ID_stall high for 2 cycles as ack for addr 8 arrives: IF/ID holds the addr-4 instruction and imem_req = 0. After release, IR = 108 with no second request to 8.
- EX_MEM_Cond = 1 with target 32'h40 while a fetch to C is pending (ack 2 cycles later): IF_ID_valid = 0. The C data is discarded, and the next request is 40, then IR = 140.
- Redirect to 80 in the same cycle as ack, with ID_stall = 1: IF/ID bubbles and the next imem_addr is 80.
- Reset pulsed low in DRAIN: outputs return to reset values asynchronously; after release, the first fetch is RESET_PC.

Source files
------------

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and constants for the PIPE fetch stage
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INSN         = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with load and flush (flush wins)
module if_id_reg
  import pipe_pkg::*;
#(
  parameter logic [31:0] NOP = NOP_INSN
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        flush,
  input  logic [31:0] ir_in,
  input  logic [31:0] npc_in,
  output logic [31:0] ir,
  output logic [31:0] npc,
  output logic        valid
);

  logic [31:0] ir_q, ir_d;
  logic [31:0] npc_q, npc_d;
  logic        valid_q, valid_d;

  // A flush only turns the slot into a bubble; NPC is left as-is.
  always_comb begin
    ir_d    = ir_q;
    npc_d   = npc_q;
    valid_d = valid_q;
    if (flush) begin
      ir_d    = NOP;
      valid_d = 1'b0;
    end else if (load) begin
      ir_d    = ir_in;
      npc_d   = npc_in;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_q    <= NOP;
      npc_q   <= 32'h0;
      valid_q <= 1'b0;
    end else begin
      ir_q    <= ir_d;
      npc_q   <= npc_d;
      valid_q <= valid_d;
    end
  end

  assign ir    = ir_q;
  assign npc   = npc_q;
  assign valid = valid_q;

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction-fetch sequencer: PC, imem handshake, IF/ID load
module fetch_ctrl
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP      = NOP_INSN
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        EX_MEM_Cond,
  input  logic [31:0] EX_MEM_ALU_output,
  input  logic        ID_stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IF_ID_IR,
  output logic [31:0] IF_ID_NPC,
  output logic        IF_ID_valid,
  output logic [31:0] pc
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  hold_ir_q, hold_ir_d;
  logic [31:0]  target_q, target_d;

  logic        ifid_load;
  logic        ifid_flush;
  logic [31:0] ifid_ir;
  logic [31:0] redirect_pc;
  logic [31:0] pc_inc;

  assign redirect_pc = EX_MEM_ALU_output & ~32'h3;
  assign pc_inc      = pc_q + 32'd4;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    hold_ir_d  = hold_ir_q;
    target_d   = target_q;
    ifid_load  = 1'b0;
    ifid_flush = 1'b0;
    ifid_ir    = imem_rdata;
    case (state_q)
      ST_BOOT: state_d = ST_FETCH;
      ST_FETCH: begin
        if (EX_MEM_Cond) begin
          ifid_flush = 1'b1;
          if (imem_ack) begin
            pc_d = redirect_pc;
          end else begin
            target_d = redirect_pc;
            state_d  = ST_DRAIN;
          end
        end else if (imem_ack) begin
          if (ID_stall) begin
            hold_ir_d = imem_rdata;
            state_d   = ST_HOLD;
          end else begin
            ifid_load = 1'b1;
            pc_d      = pc_inc;
          end
        end else if (!ID_stall) begin
          ifid_flush = 1'b1;
        end
      end
      ST_HOLD: begin
        if (EX_MEM_Cond) begin
          ifid_flush = 1'b1;
          pc_d       = redirect_pc;
          state_d    = ST_FETCH;
        end else if (!ID_stall) begin
          ifid_load = 1'b1;
          ifid_ir   = hold_ir_q;
          pc_d      = pc_inc;
          state_d   = ST_FETCH;
        end
      end
      ST_DRAIN: begin
        // The stale request must complete before the redirect target is issued.
        ifid_flush = 1'b1;
        if (EX_MEM_Cond) target_d = redirect_pc;
        if (imem_ack) begin
          pc_d    = EX_MEM_Cond ? redirect_pc : target_q;
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_BOOT;
      pc_q      <= RESET_PC;
      hold_ir_q <= NOP;
      target_q  <= 32'h0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      hold_ir_q <= hold_ir_d;
      target_q  <= target_d;
    end
  end

  if_id_reg #(.NOP(NOP)) u_if_id (
    .clk    (clk),
    .rst_n  (reset),
    .load   (ifid_load),
    .flush  (ifid_flush),
    .ir_in  (ifid_ir),
    .npc_in (pc_inc),
    .ir     (IF_ID_IR),
    .npc    (IF_ID_NPC),
    .valid  (IF_ID_valid)
  );

  assign imem_req  = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
  assign imem_addr = {pc_q[31:2], 2'b00};
  assign pc        = pc_q;

endmodule
